// File: rtl/id_inst_queue_pkg.sv
// Shared defines for the IF->ID path: instruction queue defaults and stage bus widths.
package id_inst_queue_pkg;
    localparam int IQ_DEPTH  = 4;
    localparam int IQ_PC_W   = 32;
    localparam int IQ_INST_W = 32;

    // {valid, pc, inst} as seen by the decode stage
    localparam int IQ_TO_ID_BUS_W = IQ_PC_W + IQ_INST_W + 1;
endpackage

// File: rtl/id_inst_queue_iq_ram.sv
// Instruction queue storage: one synchronous write port, one asynchronous read port.
// Contents are never cleared; validity is tracked by the controller.
module iq_ram #(
    parameter int DEPTH = 4,
    parameter int DW    = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/id_inst_queue.sv
// IF->ID instruction queue: FIFO of {pc, inst} with occupancy-based IF stall request.
// Flush drops queued and incoming entries; rst (sync, high) outranks everything.
module id_inst_queue
    import id_inst_queue_pkg::*;
#(
    parameter int DEPTH    = IQ_DEPTH,
    parameter int PC_W     = IQ_PC_W,
    parameter int INST_W   = IQ_INST_W,
    parameter int AF_LEVEL = DEPTH - 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [PC_W-1:0]          in_pc,
    input  logic [INST_W-1:0]        in_inst,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [PC_W-1:0]          out_pc,
    output logic [INST_W-1:0]        out_inst,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     stallreq_if
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = PC_W + INST_W;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);

    logic [AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;
    logic          w_push, w_pop;
    logic [DW-1:0] w_rdata;

    assign in_ready    = (r_count != FULL_CNT);
    assign out_valid   = (r_count != '0);
    assign stallreq_if = (r_count >= AF_CNT);
    assign count       = r_count;

    assign w_push = in_valid && in_ready && !flush;
    assign w_pop  = out_valid && out_ready && !flush;

    iq_ram #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) u_ram (
        .clk     (clk),
        .i_we    (w_push && !rst),
        .i_waddr (r_wptr),
        .i_wdata ({in_pc, in_inst}),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata)
    );

    // Empty queue presents a zero bubble to decode rather than stale storage.
    assign out_pc   = out_valid ? w_rdata[DW-1:INST_W] : '0;
    assign out_inst = out_valid ? w_rdata[INST_W-1:0]  : '0;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_id_inst_queue.sv
// Directed bench for id_inst_queue with a queue-based reference of the FIFO contents.
module tb_id_inst_queue;
    localparam int DEPTH = 4;
    localparam int AF    = DEPTH - 1;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, in_ready, out_valid, out_ready, stallreq_if;
    logic [31:0]   in_pc, in_inst, out_pc, out_inst;
    logic [CW-1:0] count;

    int            n_chk  = 0;
    int            n_fail = 0;
    logic [63:0]   sb[$];
    logic [63:0]   popped;

    id_inst_queue #(.DEPTH(DEPTH), .PC_W(32), .INST_W(32), .AF_LEVEL(AF)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_pc       (in_pc),
        .in_inst     (in_inst),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_pc      (out_pc),
        .out_inst    (out_inst),
        .out_ready   (out_ready),
        .count       (count),
        .stallreq_if (stallreq_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs; compare popped head before the edge, state after it.
    task automatic step(input logic r, input logic fl, input logic v,
                        input logic [31:0] pc, input logic [31:0] inst, input logic ordy);
        logic do_pop, do_push;
        rst = r; flush = fl; in_valid = v; in_pc = pc; in_inst = inst; out_ready = ordy;
        do_pop  = !r && !fl && ordy && (sb.size() != 0);
        do_push = !r && !fl && v && (sb.size() != DEPTH);
        if (do_pop) begin
            chk("pop_valid", 64'(out_valid), 64'd1);
            chk("pop_pc",    64'(out_pc),    64'(sb[0][63:32]));
            chk("pop_inst",  64'(out_inst),  64'(sb[0][31:0]));
            popped = sb.pop_front();
        end
        if (do_push) sb.push_back({pc, inst});
        if (r || fl) sb.delete();
        @(posedge clk);
        #1;
        chk("count",     64'(count),       64'(sb.size()));
        chk("out_valid", 64'(out_valid),   64'(sb.size() != 0));
        chk("in_ready",  64'(in_ready),    64'(sb.size() != DEPTH));
        chk("stallreq",  64'(stallreq_if), 64'(sb.size() >= AF));
        if (sb.size() == 0) begin
            chk("bubble", {out_pc, out_inst}, 64'd0);
        end else begin
            chk("head", {out_pc, out_inst}, sb[0]);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0; out_ready = 1'b0;

        // Reset state
        step(1, 0, 0, 32'h0, 32'h0, 0);
        step(1, 0, 1, 32'h55, 32'h66, 1);

        // Single entry, next-cycle visibility, then bubble
        step(0, 0, 1, 32'hBFC00000, 32'h3C011234, 1);
        chk("first_pc",   64'(out_pc),   64'h0BFC00000);
        chk("first_inst", 64'(out_inst), 64'h03C011234);
        step(0, 0, 0, 32'h0, 32'h0, 1);
        chk("drained_inst", 64'(out_inst), 64'd0);

        // Fill with five pushes while decode stalls; fifth is dropped
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 32'h100 + 32'(i * 4), 32'hA000_0000 + 32'(i), 0);
            if (i == 2) chk("af_at_3", 64'(stallreq_if), 64'd1);
            if (i == 3) chk("full_rdy", 64'(in_ready), 64'd0);
        end
        chk("full_cnt", 64'(count), 64'd4);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 32'h0, 32'h0, 1);
        step(0, 0, 0, 32'h0, 32'h0, 1);

        // Steady state at count=2 with concurrent push/pop; pointers wrap
        step(0, 0, 1, 32'h200, 32'hB0, 0);
        step(0, 0, 1, 32'h204, 32'hB1, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 1, 32'h300 + 32'(i * 4), 32'hC0 + 32'(i), 1);
            chk("steady_cnt", 64'(count), 64'd2);
        end

        // Flush at count=3 wins over push and pop
        step(0, 0, 1, 32'h400, 32'hD0, 0);
        step(0, 1, 1, 32'hDEAD, 32'hBEEF, 1);
        chk("flush_valid", 64'(out_valid), 64'd0);
        step(0, 0, 0, 32'h0, 32'h0, 1);

        // Head held stable during a three-cycle decode stall
        step(0, 0, 1, 32'h10, 32'h2402_0001, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 32'h0, 32'h0, 0);
            chk("hold_pc",   64'(out_pc),   64'h10);
            chk("hold_inst", 64'(out_inst), 64'h2402_0001);
        end
        step(0, 0, 0, 32'h0, 32'h0, 1);

        // Reset mid-operation while full
        for (int i = 0; i < 4; i++) step(0, 0, 1, 32'h500 + 32'(i), 32'hE0 + 32'(i), 0);
        step(1, 0, 1, 32'h600, 32'hF0, 1);
        chk("rst_rdy", 64'(in_ready), 64'd1);
        step(0, 0, 1, 32'h700, 32'hF1, 0);

        // Random traffic against the reference queue
        for (int i = 0; i < 60; i++) begin
            step(0, ($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1,
                 $urandom(), $urandom(), $urandom_range(0, 1) == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
